ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends single command bytes (LED set 0xED, LED mask, reset 0xFF, typematic 0xF3, etc.) from the FPGA to the keyboard over the same PS2_CLK/PS2_DAT pair the keyboard input path listens on. It sits beside the receive path and shares its open-drain pins through top-level tristate logic. While `busy` is high, the receive path ignores bus activity.

---
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then
// shifts one command byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        r_state;
  logic [9:0]    r_shift;
  logic [3:0]    r_edge_cnt;
  logic [TW-1:0] r_timer;
  logic          r_clk_s1, r_clk_s2, r_clk_prev, r_fall;
  logic          r_dat_s1, r_dat_s2;
  logic          r_tx_ready, r_busy, r_tx_done, r_tx_error, r_clk_oe, r_dat_oe;
  logic          w_timeout;

  // Idle bus level is high, so the synchronizers reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old value.
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat_in;
      r_dat_s2   <= r_dat_s1;
      r_fall     <= r_clk_prev & ~r_clk_s2;
    end
  end

  assign w_timeout = (r_timer == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_edge_cnt <= '0;
      r_timer    <= '0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          // tx_ready comes back one cycle after the done/error pulse that entered IDLE.
          if (tx_valid && r_tx_ready) begin
            r_shift    <= {1'b1, ~^tx_data, tx_data};
            r_edge_cnt <= '0;
            r_timer    <= '0;
            r_clk_oe   <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_INHIBIT;
          end else begin
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        S_INHIBIT: begin
          if (r_timer == INH_LAST) begin
            r_dat_oe <= 1'b1;
            r_state  <= S_START;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_START: begin
          r_clk_oe <= 1'b0;
          r_timer  <= '0;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_fall) begin
            r_timer    <= '0;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            r_dat_oe   <= ~r_shift[0];
            r_shift    <= {1'b1, r_shift[9:1]};
            if (r_edge_cnt == 4'd9) r_state <= S_ACK;
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_tx_error <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ACK: begin
          if (r_fall) begin
            r_timer <= '0;
            if (!r_dat_s2) begin
              r_state <= S_WAIT_IDLE;
            end else begin
              r_tx_error <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_tx_error <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (r_clk_s2 && r_dat_s2) begin
            r_tx_done <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_tx_error <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ready   = r_tx_ready;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;
  assign tx_error   = r_tx_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule
